// File: rtl/maxpool_relu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_relu_if                                                            |
// | Control handshake plus conv-buffer read and pool-buffer write ports.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface maxpool_relu_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_AW    = 13,
    parameter int POOL_AW    = 11
);
    logic                         start;
    logic                         done;
    logic [CONV_AW-1:0]           conv_addr;
    logic                         conv_en;
    logic signed [DATA_WIDTH-1:0] conv_q;
    logic [POOL_AW-1:0]           pool_addr;
    logic                         pool_en;
    logic                         pool_we;
    logic signed [DATA_WIDTH-1:0] pool_d;

    modport master (
        input  start, conv_q,
        output done, conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d
    );

    modport slave (
        output start, conv_q,
        input  done, conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d
    );
endinterface
`default_nettype wire

// File: rtl/maxpool_relu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxpool_relu                                                               |
// | 2x2 stride-2 max pooling with optional ReLU, conv BRAM -> pool BRAM.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module maxpool_relu #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    parameter int APPLY_RELU = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    maxpool_relu_if.master  bus
);
    localparam int c_out_size = IMG_SIZE / 2;
    localparam int c_conv_n   = CHANNELS * IMG_SIZE * IMG_SIZE;
    localparam int c_pool_n   = CHANNELS * c_out_size * c_out_size;
    localparam int c_conv_aw  = (c_conv_n > 1) ? $clog2(c_conv_n) : 1;
    localparam int c_pool_aw  = (c_pool_n > 1) ? $clog2(c_pool_n) : 1;
    localparam int c_ch_w     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_pos_w    = (c_out_size > 1) ? $clog2(c_out_size) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_DRAIN  = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // k selects (dr, dc) = (k[1], k[0]) inside the 2x2 window.
    function automatic logic [c_conv_aw-1:0] conv_addr_of(input int ch, input int pr,
                                                          input int pc, input int k);
        return c_conv_aw'((ch * IMG_SIZE + 2 * pr + k / 2) * IMG_SIZE + 2 * pc + k % 2);
    endfunction

    function automatic logic [c_pool_aw-1:0] pool_addr_of(input int ch, input int pr,
                                                          input int pc);
        return c_pool_aw'((ch * c_out_size + pr) * c_out_size + pc);
    endfunction

    state_t                       r_state;
    logic [c_ch_w-1:0]            r_ch;
    logic [c_pos_w-1:0]           r_pr;
    logic [c_pos_w-1:0]           r_pc;
    logic [1:0]                   r_k;
    logic                         r_vld;
    logic                         r_first;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic [c_conv_aw-1:0]         r_conv_addr;
    logic                         r_conv_en;
    logic [c_pool_aw-1:0]         r_pool_addr;
    logic                         r_pool_we;
    logic signed [DATA_WIDTH-1:0] r_pool_d;
    logic                         r_done;

    logic signed [DATA_WIDTH-1:0] w_max_nxt;
    logic signed [DATA_WIDTH-1:0] w_result;
    logic                         w_last_col;
    logic                         w_last_row;
    logic                         w_last_win;
    logic [c_ch_w-1:0]            w_ch_nxt;
    logic [c_pos_w-1:0]           w_pr_nxt;
    logic [c_pos_w-1:0]           w_pc_nxt;

    // First sample of a window loads unconditionally, so no sentinel is needed.
    always_comb begin
        w_max_nxt = r_max;
        if (r_vld && (r_first || (bus.conv_q > r_max))) begin
            w_max_nxt = bus.conv_q;
        end
    end

    assign w_result   = ((APPLY_RELU != 0) && w_max_nxt[DATA_WIDTH-1]) ? '0 : w_max_nxt;
    assign w_last_col = (int'(r_pc) == c_out_size - 1);
    assign w_last_row = (int'(r_pr) == c_out_size - 1);
    assign w_last_win = w_last_col && w_last_row && (int'(r_ch) == CHANNELS - 1);

    always_comb begin
        w_pc_nxt = r_pc + 1'b1;
        w_pr_nxt = r_pr;
        w_ch_nxt = r_ch;
        if (w_last_col) begin
            w_pc_nxt = '0;
            w_pr_nxt = r_pr + 1'b1;
            if (w_last_row) begin
                w_pr_nxt = '0;
                w_ch_nxt = r_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_pr        <= '0;
            r_pc        <= '0;
            r_k         <= '0;
            r_vld       <= 1'b0;
            r_first     <= 1'b0;
            r_max       <= '0;
            r_conv_addr <= '0;
            r_conv_en   <= 1'b0;
            r_pool_addr <= '0;
            r_pool_we   <= 1'b0;
            r_pool_d    <= '0;
            r_done      <= 1'b0;
        end else begin
            // Read data returns one cycle after the enable; track which sample it is.
            r_vld     <= r_conv_en;
            r_first   <= r_conv_en && (r_k == 2'd0);
            r_max     <= w_max_nxt;
            r_pool_we <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ch        <= '0;
                        r_pr        <= '0;
                        r_pc        <= '0;
                        r_k         <= '0;
                        r_conv_en   <= 1'b1;
                        r_conv_addr <= conv_addr_of(0, 0, 0, 0);
                        r_state     <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_k == 2'd3) begin
                        r_k       <= '0;
                        r_conv_en <= 1'b0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_k         <= r_k + 1'b1;
                        r_conv_addr <= conv_addr_of(int'(r_ch), int'(r_pr), int'(r_pc),
                                                    int'(r_k) + 1);
                    end
                end
                S_DRAIN: begin
                    r_pool_we   <= 1'b1;
                    r_pool_addr <= pool_addr_of(int'(r_ch), int'(r_pr), int'(r_pc));
                    r_pool_d    <= w_result;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_last_win) begin
                        r_ch    <= '0;
                        r_pr    <= '0;
                        r_pc    <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_ch        <= w_ch_nxt;
                        r_pr        <= w_pr_nxt;
                        r_pc        <= w_pc_nxt;
                        r_conv_en   <= 1'b1;
                        r_conv_addr <= conv_addr_of(int'(w_ch_nxt), int'(w_pr_nxt),
                                                    int'(w_pc_nxt), 0);
                        r_state     <= S_RD;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.conv_addr = r_conv_addr;
    assign bus.conv_en   = r_conv_en;
    assign bus.pool_addr = r_pool_addr;
    assign bus.pool_en   = r_pool_we;
    assign bus.pool_we   = r_pool_we;
    assign bus.pool_d    = r_pool_d;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: doc/maxpool_relu.md
# maxpool_relu

Consumer of the conv buffer BRAM: after `conv2d` asserts `done`, this block reads the feature maps back and applies 2×2/stride-2 max pooling with optional ReLU. It writes the pooled maps into the pool buffer BRAM that feeds the next layer. Control is a single start/done handshake, and one window is processed at a time with a fixed 6-cycle cadence.

## Interface
- `DATA_WIDTH`, default 16: signed fixed-point sample width (Q format unchanged, no rescaling).
- `CHANNELS`, default 8: number of feature maps.
- `IMG_SIZE`, default 28: input map height = width; `OUT_SIZE = IMG_SIZE/2` (floor).
- `APPLY_RELU`, default 1: 1 clamps the pooled result at 0; 0 passes the raw max.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle request, sampled only in IDLE.
- `conv_addr` output `$clog2(CHANNELS*IMG_SIZE*IMG_SIZE)`: conv buffer read address (registered).
- `conv_en` output 1: conv buffer read enable (registered).
- `conv_q` input `DATA_WIDTH` signed: read data, valid the cycle after `conv_en`.
- `pool_addr` output `$clog2(CHANNELS*OUT_SIZE*OUT_SIZE)`: pool buffer write address.
- `pool_en` output 1: pool buffer enable, always equal to `pool_we`.
- `pool_we` output 1: write strobe.
- `pool_d` output `DATA_WIDTH` signed: write data.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE → RD (4 cycles, k = 0..3) → DRAIN (1 cycle) → WRITE (1 cycle) → RD of the next window, or FINISH after the last window → IDLE.
- Window order: channel c outermost, then pool row pr, then pool col pc. `pool_addr = (c*OUT_SIZE + pr)*OUT_SIZE + pc`.
- Read order within a window, k = 0..3, uses (dr, dc) = (0,0), (0,1), (1,0), (1,1). `conv_addr = (c*IMG_SIZE + 2pr+dr)*IMG_SIZE + 2pc+dc`.
- Max register:
  - Loads `conv_q` directly for the first sample.
  - For the remaining samples, updates only if `conv_q` > the current max (signed compare).
  - There is no sentinel init.
- Result: `pool_d = (APPLY_RELU && max < 0) ? 0 : max`. Full width, with no shift or saturation.
- Odd `IMG_SIZE`: the last input row and column are never addressed.
- `start` outside IDLE, including during FINISH, is ignored. No restart occurs until IDLE is re-entered.
- `conv_q` is sampled only in the cycles after `conv_en`; its value is don't-care at all other times.

## Timing
- Reset values: `conv_addr` = 0, `conv_en` = 0, `pool_addr` = 0, `pool_en` = 0, `pool_we` = 0, `pool_d` = 0, `done` = 0. State = IDLE and all counters = 0.
- Let s be the cycle in which `start` is sampled high in IDLE, and window index w = 0..NW-1, where `NW = CHANNELS*OUT_SIZE^2`.
- Per window w:
  - `conv_en` is high in cycles s+1+6w .. s+4+6w.
  - `conv_q` is captured in cycles s+2+6w .. s+5+6w.
  - `pool_en`/`pool_we` are high for exactly one cycle, s+6+6w, with `pool_addr`/`pool_d` valid in that cycle.
- `conv_en` is low in cycles s+5+6w and s+6+6w. Read and write never overlap.
- `done` is high only in cycle s+1+6·NW; the block is in IDLE from s+2+6·NW.
- `reset` mid-operation:
  - The next cycle shows all outputs at their reset values and the state in IDLE.
  - No further writes are issued and no `done` pulse is produced for the aborted run.
- A `start` coincident with `reset` is ignored.

## Test plan
- CHANNELS=1, IMG_SIZE=4, conv buffer holds 0..15 (row-major), start at s:
  - Writes (addr, data) = (0,5), (1,7), (2,13), (3,15) at cycles s+6, s+12, s+18, s+24.
  - `done` pulses at s+25.
  - `conv_en` is high exactly 16 cycles.
- Negative window, IMG_SIZE=2, buffer {-1,-2,-3,-4}:
  - With APPLY_RELU=1, `pool_d` = 0.
  - With APPLY_RELU=0, `pool_d` = -1.
  - Buffer {-32768,-32768,-32768,-32768} with APPLY_RELU=0 gives -32768.
- CHANNELS=2, IMG_SIZE=5:
  - 8 writes to addr 0..7, in order.
  - No `conv_addr` ever falls on row 4 or col 4 of either channel.
  - Channel 1's first read is address 25.
- `start` pulsed again at s+3 and s+10:
  - Both pulses are ignored.
  - The write sequence and `done` timing are identical to a single-start run.
- `reset` asserted at s+9 in the 4×4 case:
  - From s+10, `conv_en`, `pool_we` and `done` are 0 and stay 0 until a new `start`.
  - Only the write at s+6 has occurred.
  - A subsequent start reproduces the full first-scenario results.
